// File: rtl/quad_enc_pkg.sv
// Shared definitions for the quadrature decoder: step classification,
// Gray-code successor and accumulator sizing.
package quad_enc_pkg;

  localparam int ACC_W = 4;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_CW   = 2'd1,
    STEP_CCW  = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  // Clockwise order of {A,B}: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] cw_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  function automatic step_e classify_step(input logic [1:0] prev_ab,
                                          input logic [1:0] cur_ab);
    if (cur_ab == prev_ab)          return STEP_NONE;
    if (cur_ab == cw_next(prev_ab)) return STEP_CW;
    if (prev_ab == cw_next(cur_ab)) return STEP_CCW;
    return STEP_ERR;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: 2-flop sync, debounce, x4 decode, detent divider
// and signed position counter (wrapping or saturating).
module quad_channel
  import quad_enc_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DETENT_DIV      = 4,
  parameter int SATURATE        = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             pos_clear_i,
  output logic             cw_o,
  output logic             ccw_o,
  output logic             step_err_o,
  output logic [CNT_W-1:0] position_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
  localparam logic signed [ACC_W-1:0] ACC_ONE = $signed(ACC_W'(1));
  localparam logic signed [ACC_W-1:0] DET_P   = $signed(ACC_W'(DETENT_DIV));
  localparam logic signed [ACC_W-1:0] DET_N   = -DET_P;
  localparam logic signed [CNT_W-1:0] POS_ONE = $signed(CNT_W'(1));
  localparam logic signed [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  function automatic logic signed [CNT_W-1:0] pos_inc(input logic signed [CNT_W-1:0] p);
    if (SATURATE != 0 && p == POS_MAX) return p;
    return p + POS_ONE;
  endfunction

  function automatic logic signed [CNT_W-1:0] pos_dec(input logic signed [CNT_W-1:0] p);
    if (SATURATE != 0 && p == POS_MIN) return p;
    return p - POS_ONE;
  endfunction

  logic [1:0]              s1_q, s2_q;
  logic [1:0]              cand_q, cand_d;
  logic [DB_W-1:0]         cnt_q, cnt_d;
  logic [1:0]              stable_q, stable_d;
  logic [1:0]              prev_q, prev_d;
  logic                    base_vld_q, base_vld_d;
  logic                    vld_p1_q, vld_p1_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [CNT_W-1:0] pos_q, pos_d;
  logic                    cw_q, cw_d, ccw_q, ccw_d, err_q, err_d;
  logic                    moving;
  step_e                   step;

  // Stage p0: debounce of the synchronised pair. Before a baseline exists
  // every settled value counts as new so the first pair is always accepted.
  always_comb begin
    moving     = !base_vld_q || (s2_q != stable_q);
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    prev_d     = prev_q;
    base_vld_d = base_vld_q;
    vld_p1_d   = 1'b0;
    if (!moving) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = DB_W'(1);
    end else if (cnt_q == DB_MAX) begin
      stable_d   = cand_q;
      cnt_d      = '0;
      base_vld_d = 1'b1;
      if (base_vld_q) begin
        prev_d   = stable_q;
        vld_p1_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  // Stage p1: decode the accepted transition and run the detent divider
  always_comb begin
    step  = classify_step(prev_q, stable_q);
    acc_d = acc_q;
    pos_d = pos_q;
    cw_d  = 1'b0;
    ccw_d = 1'b0;
    err_d = 1'b0;
    if (vld_p1_q) begin
      case (step)
        STEP_CW: begin
          if (acc_q + ACC_ONE == DET_P) begin
            cw_d  = 1'b1;
            pos_d = pos_inc(pos_q);
            acc_d = '0;
          end else begin
            acc_d = acc_q + ACC_ONE;
          end
        end
        STEP_CCW: begin
          if (acc_q - ACC_ONE == DET_N) begin
            ccw_d = 1'b1;
            pos_d = pos_dec(pos_q);
            acc_d = '0;
          end else begin
            acc_d = acc_q - ACC_ONE;
          end
        end
        STEP_ERR: begin
          err_d = 1'b1;
          acc_d = '0;
        end
        default: ;
      endcase
    end
    if (pos_clear_i) begin
      pos_d = '0;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      stable_q   <= '0;
      prev_q     <= '0;
      base_vld_q <= 1'b0;
      vld_p1_q   <= 1'b0;
      acc_q      <= '0;
      pos_q      <= '0;
      cw_q       <= 1'b0;
      ccw_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_q       <= {a_i, b_i};
      s2_q       <= s1_q;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      prev_q     <= prev_d;
      base_vld_q <= base_vld_d;
      vld_p1_q   <= vld_p1_d;
      acc_q      <= acc_d;
      pos_q      <= pos_d;
      cw_q       <= cw_d;
      ccw_q      <= ccw_d;
      err_q      <= err_d;
    end
  end

  assign cw_o       = cw_q;
  assign ccw_o      = ccw_q;
  assign step_err_o = err_q;
  assign position_o = pos_q;

endmodule

// File: rtl/quad_encoder_decoder.sv
// Multi-channel quadrature decoder: one independent quad_channel per
// encoder, positions packed channel-major into a flat bus.
module quad_encoder_decoder
  import quad_enc_pkg::*;
#(
  parameter int NUM_CH          = 1,
  parameter int CNT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DETENT_DIV      = 4,
  parameter int SATURATE        = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       A,
  input  logic [NUM_CH-1:0]       B,
  input  logic [NUM_CH-1:0]       pos_clear,
  output logic [NUM_CH-1:0]       Clockwise,
  output logic [NUM_CH-1:0]       counterClockwise,
  output logic [NUM_CH*CNT_W-1:0] position,
  output logic [NUM_CH-1:0]       step_err
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    quad_channel #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DETENT_DIV     (DETENT_DIV),
      .SATURATE       (SATURATE)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .a_i        (A[i]),
      .b_i        (B[i]),
      .pos_clear_i(pos_clear[i]),
      .cw_o       (Clockwise[i]),
      .ccw_o      (counterClockwise[i]),
      .step_err_o (step_err[i]),
      .position_o (position[i*CNT_W +: CNT_W])
    );
  end

endmodule
